pwm_audio_out: RTL and testbench
================================

# pwm_audio_out

Audio output back-end that consumes the `tone_data`/`tone_valid` sample stream from the tone generator and drives a 1-bit PWM speaker output. It paces the generator by driving the 2-bit `sample_phase` request code, buffers returned samples in a small FIFO, and pops one sample per `SAMPLE_RATE` tick. Each sample is volume-scaled about midscale and applied to an 8-bit PWM duty register, updated only at PWM period boundaries. It sits between the tone generator and the board audio pins (PWM plus amplifier shutdown).

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock in Hz.
- `SAMPLE_RATE`, 8000, sample pop rate in Hz; tick period `TICK_DIV = CLK_FREQ/SAMPLE_RATE` (12500).
- `FIFO_DEPTH`, 4, sample FIFO entries (power of 2, 2..16).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = play; 0 = mute and stop requesting.
- `volume`  in  3  gain = (volume+1)/8; 7 = unity.
- `tone_data`  in  8  unsigned sample, midscale 8'h80.
- `tone_valid`  in  1  one-cycle strobe qualifying `tone_data`.
- `sample_phase`  out  2  request code to the generator: 00 = request (one cycle), 01 = idle/waiting, 10 = FIFO full, 11 = disabled.
- `pwm_out`  out  1  PWM audio output.
- `audio_sd`  out  1  amplifier enable; equals registered `enable`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `underrun`  out  1  sticky; set when a tick finds the FIFO empty; cleared only by reset.

## Operation
- Reset values: `sample_phase`=11, `pwm_out`=0, `audio_sd`=0, `fifo_level`=0, `underrun`=0. Internal state: duty=8'h80, tick counter=0, PWM counter=0, outstanding=0.
- Request FSM, states IDLE, WAIT, FULL, OFF:
  - OFF (phase 11): entered when `enable`=0. Leave to IDLE when `enable`=1.
  - IDLE: if level+outstanding < `FIFO_DEPTH`, drive 00 for exactly one cycle, set outstanding, and go to WAIT. Otherwise go to FULL (phase 10).
  - WAIT (phase 01): exit to IDLE on `tone_valid`, or after a 4-cycle timeout with no `tone_valid`, which clears outstanding and discards the request.
  - FULL (phase 10): return to IDLE when level < `FIFO_DEPTH`.
  - Consecutive 00 cycles never occur; there is at least one non-00 cycle between requests.
- FIFO push: occurs on `tone_valid`=1 when not full. A `tone_valid` while full is dropped. A `tone_valid` without an outstanding request is still pushed if there is room.
- Simultaneous push and pop: both occur and the level is unchanged.
- Tick counter: counts 0..`TICK_DIV`-1 and wraps.
- At wrap with `enable`=1:
  - If the FIFO is non-empty, pop the head into the sample register.
  - If empty, load 8'h80 and set `underrun`.
- Scaling:
  - s = sample - 128, signed 9-bit.
  - p = s * (volume+1), signed 13-bit.
  - duty_next = (p >>> 3) + 128. This is an arithmetic shift; the result is always 0..255, so no saturation is needed.
- PWM:
  - 8-bit free-running counter with a period of 256 cycles.
  - `pwm_out` = (cnt < duty), registered.
  - duty loads duty_next only when cnt wraps 255→0, so no mid-period glitch.
- `enable`=0:
  - FSM goes to OFF.
  - The FIFO flushes (level forced to 0 next cycle).
  - duty_next is forced to 8'h80.
  - `pwm_out` is held 0 and `audio_sd`=0.
  - The tick and PWM counters keep running.

## Timing
- Generator contract: `tone_valid` arrives 1 cycle after the 00 cycle (registered generator). The timeout covers up to 4 cycles.
- Request to FIFO entry: the 00 cycle is N, `tone_valid` is at N+1, and `fifo_level` increments at N+2.
- Pop to audible: the tick wrap is at cycle T, duty_next is valid at T+1, and duty takes effect at the next PWM wrap after T+1 (≤257 cycles).
- `enable` is registered once. `audio_sd` and the FSM react 1 cycle after `enable` changes.
- Reset mid-request: an outstanding request is abandoned. A `tone_valid` arriving after reset deassertion is treated as an unsolicited push.

## Test plan
- Reset and enable=1 with a responding generator model → first `sample_phase`=00 within 3 cycles of reset release. `fifo_level` reaches 4, then `sample_phase`=10 steady.
- Constant samples of 8'hC0, volume=7 → after the first tick, duty=192: `pwm_out` high 192 of every 256 cycles.
- Same stream with volume=3 → duty=(64*4>>>3)+128=160. Sample 8'h00 with volume=3 gives duty=64. Sample 8'hFF with volume=7 gives duty=255.
- Generator never asserts `tone_valid` → each request times out after 4 cycles. At the first tick, duty stays 128 and `underrun`=1, which stays set after traffic resumes.
- Push and pop in the same cycle at level 2 → level stays 2. `tone_valid` at level 4 → dropped, level stays 4.
- enable 1→0 mid-stream → next cycle: `sample_phase`=11, `audio_sd`=0, `pwm_out`=0, `fifo_level`=0. Re-enable → requests resume from IDLE.

Source files
------------

// File: rtl/pwm_audio_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_audio_out: paced sample FIFO, volume scaler and 8-bit PWM speaker drive |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_audio_out #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SAMPLE_RATE = 8000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2:0]                    volume,
  input  logic [7:0]                    tone_data,
  input  logic                          tone_valid,
  output logic [1:0]                    sample_phase,
  output logic                          pwm_out,
  output logic                          audio_sd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int c_tick_div = CLK_FREQ / SAMPLE_RATE;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int TW         = $clog2(c_tick_div);

  localparam logic [TW-1:0] c_tick_max = TW'(c_tick_div - 1);
  localparam logic [LW-1:0] c_depth_l  = LW'(FIFO_DEPTH);
  localparam logic [LW:0]   c_depth_w  = (LW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_OFF  = 2'd3
  } state_t;

  state_t          r_state, w_next_state;
  logic            r_enable;
  logic [1:0]      r_wait_cnt;
  logic            r_outstanding;
  logic            w_req, w_clr_outst, w_room;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            w_full, w_empty, w_push, w_pop;

  logic [TW-1:0]   r_tick;
  logic            w_tick_wrap;
  logic [7:0]      r_sample;
  logic            r_underrun;

  logic signed [12:0] w_s, w_gain, w_p;
  logic [7:0]      w_duty_next;
  logic [7:0]      r_pwm_cnt, r_duty;
  logic            r_pwm;

  assign w_full      = (r_level == c_depth_l);
  assign w_empty     = (r_level == '0);
  assign w_room      = (({1'b0, r_level} + (LW+1)'(r_outstanding)) < c_depth_w);
  assign w_push      = enable && tone_valid && !w_full;
  assign w_tick_wrap = enable && (r_tick == c_tick_max);
  assign w_pop       = w_tick_wrap && !w_empty;

  // Request FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_OFF;
      r_enable      <= 1'b0;
      r_wait_cnt    <= 2'd0;
      r_outstanding <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_enable   <= enable;
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
      if (w_clr_outst)
        r_outstanding <= 1'b0;
      else if (w_req)
        r_outstanding <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    sample_phase = 2'b11;
    w_req        = 1'b0;
    w_clr_outst  = 1'b0;
    case (r_state)
      ST_OFF: begin
        sample_phase = 2'b11;
        w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_room) begin
          sample_phase = 2'b00;
          w_req        = 1'b1;
          w_next_state = ST_WAIT;
        end else begin
          sample_phase = 2'b10;
          w_next_state = ST_FULL;
        end
      end
      ST_WAIT: begin
        sample_phase = 2'b01;
        if (tone_valid || (r_wait_cnt == 2'd3)) begin
          w_clr_outst  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_FULL: begin
        sample_phase = 2'b10;
        if (!w_full)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_OFF;
    endcase
    if (!enable) begin
      w_next_state = ST_OFF;
      w_req        = 1'b0;
      w_clr_outst  = 1'b1;
    end
  end

  // Sample FIFO; disabling flushes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (!enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= tone_data;
  end

  // Sample-rate tick: pop one sample, or fall back to midscale on empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick     <= '0;
      r_sample   <= 8'h80;
      r_underrun <= 1'b0;
    end else begin
      r_tick <= (r_tick == c_tick_max) ? '0 : r_tick + TW'(1);
      if (w_tick_wrap) begin
        if (!w_empty) begin
          r_sample <= r_mem[r_rd_ptr];
        end else begin
          r_sample   <= 8'h80;
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // Gain of (volume+1)/8 about midscale; result stays within 0..255
  assign w_s         = $signed({5'b0, r_sample}) - 13'sd128;
  assign w_gain      = $signed({9'b0, {1'b0, volume} + 4'd1});
  assign w_p         = w_s * w_gain;
  assign w_duty_next = enable ? 8'((w_p >>> 3) + 13'sd128) : 8'h80;

  // Duty reloads only at the period boundary to avoid mid-period glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= 8'd0;
      r_duty    <= 8'h80;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_pwm_cnt == 8'hFF)
        r_duty <= w_duty_next;
      r_pwm <= enable && (r_pwm_cnt < r_duty);
    end
  end

  assign pwm_out    = r_pwm;
  assign audio_sd   = r_enable;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_audio_out: scoreboard bench for pwm_audio_out with a generator model |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pwm_audio_out;

  localparam int c_tick = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] volume;
  logic [7:0] tone_data;
  logic       tone_valid;
  logic [1:0] sample_phase;
  logic       pwm_out;
  logic       audio_sd;
  logic [2:0] fifo_level;
  logic       underrun;

  pwm_audio_out #(
    .CLK_FREQ    (512_000),
    .SAMPLE_RATE (1000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .volume       (volume),
    .tone_data    (tone_data),
    .tone_valid   (tone_valid),
    .sample_phase (sample_phase),
    .pwm_out      (pwm_out),
    .audio_sd     (audio_sd),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         gen_on    = 1'b0;
  bit         man_valid = 1'b0;
  logic [7:0] gen_sample = 8'h80;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input int val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic observe(input int got);
    exp_t e;
    if (sb_q.size() > 0)
      e = sb_q.pop_front();
    else
      e = '{"scoreboard_empty", -1};
    check(e.tag, got, e.val);
  endtask

  task automatic measure_duty(output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * c_tick) @(negedge clk);
  endtask

  task automatic set_gen(input bit on);
    @(posedge clk);
    #2;
    gen_on = on;
    @(negedge clk);
  endtask

  task automatic pulse_valid();
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_level(input int lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(fifo_level) == lvl) break;
      @(negedge clk);
    end
  endtask

  task automatic first_request(output int found);
    found = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (found == 0 && sample_phase == 2'b00) found = 1;
    end
  endtask

  // Registered generator: answers a 00 request one cycle later
  initial begin
    bit req_seen;
    tone_valid = 1'b0;
    tone_data  = 8'h80;
    forever begin
      @(negedge clk);
      req_seen = gen_on && (sample_phase == 2'b00);
      @(posedge clk);
      #1;
      tone_valid = req_seen || man_valid;
      tone_data  = gen_sample;
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v, t0, gap;
    reset  = 1'b1;
    enable = 1'b0;
    volume = 3'd7;
    repeat (3) @(negedge clk);

    expect_val("reset_phase", 3);
    expect_val("reset_pwm", 0);
    expect_val("reset_sd", 0);
    expect_val("reset_level", 0);
    expect_val("reset_underrun", 0);
    observe(int'(sample_phase));
    observe(int'(pwm_out));
    observe(int'(audio_sd));
    observe(int'(fifo_level));
    observe(int'(underrun));

    gen_sample = 8'hC0;
    gen_on     = 1'b1;
    enable     = 1'b1;
    reset      = 1'b0;
    expect_val("first_request", 1);
    first_request(v);
    observe(v);

    expect_val("fill_level", 4);
    wait_level(4, 60);
    observe(int'(fifo_level));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_val("full_phase", 2);
      observe(int'(sample_phase));
    end

    expect_val("duty_c0_v7", 192);
    wait_ticks(6);
    measure_duty(v);
    observe(v);

    volume = 3'd3;
    expect_val("duty_c0_v3", 160);
    wait_ticks(1);
    measure_duty(v);
    observe(v);

    gen_sample = 8'h00;
    expect_val("duty_00_v3", 64);
    wait_ticks(6);
    measure_duty(v);
    observe(v);

    gen_sample = 8'hFF;
    volume     = 3'd7;
    expect_val("duty_ff_v7", 255);
    wait_ticks(6);
    measure_duty(v);
    observe(v);
    expect_val("no_underrun", 0);
    observe(int'(underrun));

    // Align a push with a tick pop at level 2
    set_gen(1'b0);
    wait_level(3, c_tick + 100);
    wait_level(2, c_tick + 100);
    expect_val("pp_start_level", 2);
    observe(int'(fifo_level));
    repeat (c_tick - 2) @(negedge clk);
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    @(negedge clk);
    expect_val("push_pop_level", 2);
    observe(int'(fifo_level));

    pulse_valid();
    pulse_valid();
    expect_val("unsolicited_fill", 4);
    observe(int'(fifo_level));
    pulse_valid();
    expect_val("drop_when_full", 4);
    observe(int'(fifo_level));

    expect_val("underrun_set", 1);
    for (int i = 0; i < 6 * c_tick; i++) begin
      if (underrun) break;
      @(negedge clk);
    end
    observe(int'(underrun));
    expect_val("empty_level", 0);
    observe(int'(fifo_level));

    t0  = -1;
    gap = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_phase == 2'b00) begin
        if (t0 < 0) begin
          t0 = i;
        end else begin
          gap = i - t0;
          break;
        end
      end
    end
    expect_val("timeout_gap", 5);
    observe(gap);

    expect_val("underrun_duty", 128);
    repeat (300) @(negedge clk);
    measure_duty(v);
    observe(v);

    gen_sample = 8'hC0;
    set_gen(1'b1);
    expect_val("underrun_sticky", 1);
    expect_val("resume_duty", 192);
    wait_ticks(6);
    observe(int'(underrun));
    measure_duty(v);
    observe(v);

    enable = 1'b0;
    @(negedge clk);
    expect_val("off_phase", 3);
    expect_val("off_sd", 0);
    expect_val("off_pwm", 0);
    expect_val("off_level", 0);
    observe(int'(sample_phase));
    observe(int'(audio_sd));
    observe(int'(pwm_out));
    observe(int'(fifo_level));
    expect_val("muted_duty", 0);
    measure_duty(v);
    observe(v);

    enable = 1'b1;
    expect_val("re_request", 1);
    first_request(v);
    observe(v);
    expect_val("refill_level", 4);
    wait_level(4, 60);
    observe(int'(fifo_level));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
